pwm_sample_scheduler: RTL and testbench
=======================================

# pwm_sample_scheduler

Sample-rate scheduler that sits in front of the `PWM` duty-cycle generator in the audio playback path. It buffers incoming samples in a small FIFO behind a valid/ready handshake. It releases exactly one sample to the PWM duty input every `sample_div` clock cycles. It also reports buffer level and underrun events to the upstream sample source.

## Interface
- `RESOLUTION_BITS`, 8, width of a sample / PWM duty word.
- `FIFO_DEPTH`, 4, sample buffer entries; power of two, ≥2.
- `DIV_BITS`, 16, width of the sample-period divider.
- `PRIME_LEVEL`, 2, FIFO level required before playback starts; 1..`FIFO_DEPTH`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  playback enable; low stops playback and flushes the FIFO.
- `sample_div`  in  `DIV_BITS`  clock cycles per sample; 0 is treated as 1.
- `s_valid`  in  1  upstream sample valid.
- `s_data`  in  `RESOLUTION_BITS`  upstream sample.
- `s_ready`  out  1  FIFO can accept a word this cycle.
- `duty_out`  out  `RESOLUTION_BITS`  duty word driven to `PWM.pwm_in`.
- `sample_strobe`  out  1  one-cycle pulse in the cycle `duty_out` takes a new value.
- `underrun`  out  1  one-cycle pulse when a sample tick finds the FIFO empty.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.

## Operation
- FSM states:
  - IDLE: enter from reset or `enable`=0. `enable`=1 → PRIME.
  - PRIME: `fifo_level` ≥ `PRIME_LEVEL` → RUN.
  - RUN: plays samples.
  - Any state with `enable`=0 → IDLE next cycle.
- FIFO: circular buffer with registered read and write pointers.
  - `s_ready` = (`fifo_level` != `FIFO_DEPTH`).
  - A push occurs when `s_valid` && `s_ready`. Pushes are accepted in all states, including IDLE.
- Flush: in the cycle the FSM leaves PRIME or RUN for IDLE, both pointers and `fifo_level` clear. A push in that same cycle is discarded.
- Divider:
  - `div_cnt` is held at 0 outside RUN.
  - In RUN, a tick occurs when `div_cnt` ≥ max(`sample_div`,1) − 1; `div_cnt` then returns to 0, otherwise it increments.
  - A mid-run shrink of `sample_div` below `div_cnt` ticks immediately.
- Tick with FIFO non-empty: pop the head; `duty_out` ← head; `sample_strobe` pulses.
- Tick with FIFO empty: `underrun` pulses; `duty_out` is per Configuration; no pop.
- Simultaneous push and pop: `fifo_level` is unchanged. A push into an empty FIFO on a tick cycle is not visible to that tick, so it still underruns.
- `duty_out` = 0 in IDLE and PRIME. The first RUN sample is popped on the first tick, `sample_div` cycles after entering RUN.

## Timing
- Reset values: `s_ready`=0 while `rst_n` is low, 1 from the first edge after release. `duty_out`=0, `sample_strobe`=0, `underrun`=0, `fifo_level`=0, state IDLE.
- Reset mid-operation: outputs clear immediately and asynchronously; FIFO contents are lost.
- Push-to-level latency: 1 cycle (`fifo_level` is registered).
- Tick-to-output: `duty_out`, `sample_strobe` and `underrun` update on the clock edge that ends the tick cycle.
- Sample period: exactly max(`sample_div`,1) cycles between `sample_strobe` pulses while the FIFO never empties.
- `enable` low → `duty_out`=0 and state IDLE one edge later.

## Configuration
- `PWM_SCHED_UNDERRUN_HOLD_EN` defined: on underrun, `duty_out` holds the last played sample.
- `PWM_SCHED_UNDERRUN_HOLD_EN` undefined: on underrun, `duty_out` ← midscale, i.e. 2^(`RESOLUTION_BITS`−1) (0x80 for 8 bits). This gives 50% duty, i.e. silence.
- `sample_strobe` does not pulse on underrun in either configuration.

## Test plan
- Reset with defaults, then push 0x10, 0x20, 0x30, 0x40 with `enable`=0 → `s_ready` drops after the 4th push, `fifo_level`=4, `duty_out`=0.
- `enable`=1, `sample_div`=5, FIFO prefilled with 0x10..0x40 → `duty_out` steps 0x10, 0x20, 0x30, 0x40 on `sample_strobe` pulses exactly 5 cycles apart, first pulse 5 cycles after RUN entry.
- Continue with no pushes after 0x40 → next tick: `underrun`=1, `duty_out`=0x40 with macro, 0x80 without.
- RUN with `sample_div`=0 and `s_valid` held high → one `sample_strobe` every cycle, `fifo_level` stays constant, no `underrun`.
- Drop `enable` mid-RUN with `fifo_level`=3 → next edge: `fifo_level`=0, `duty_out`=0, state IDLE. Re-enable with a single push → stays in PRIME (`PRIME_LEVEL`=2) until a second push.
- Assert `rst_n`=0 asynchronously between edges mid-RUN → all outputs 0 before the next edge, FIFO empty after release.

Source files
------------

// File: rtl/pwm_sample_scheduler.sv
// Sample-rate scheduler: FIFO-buffers upstream samples and releases one to the PWM duty input
// every sample_div cycles. Define PWM_SCHED_UNDERRUN_HOLD_EN to hold the last sample on underrun.
module pwm_sample_scheduler #(
  parameter int unsigned RESOLUTION_BITS = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned DIV_BITS        = 16,
  parameter int unsigned PRIME_LEVEL     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [DIV_BITS-1:0]              sample_div,
  input  logic                             s_valid,
  input  logic [RESOLUTION_BITS-1:0]       s_data,
  output logic                             s_ready,
  output logic [RESOLUTION_BITS-1:0]       duty_out,
  output logic                             sample_strobe,
  output logic                             underrun,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e                     state_q, state_d;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]            level_q, level_d;
  logic [DIV_BITS-1:0]        div_cnt_q, div_cnt_d;
  logic [RESOLUTION_BITS-1:0] duty_q, duty_d;
  logic                       strobe_q, strobe_d;
  logic                       underrun_q, underrun_d;
  logic                       ready_q;

  logic [RESOLUTION_BITS-1:0] mem [FIFO_DEPTH];

  logic                       flush;
  logic                       push;
  logic                       pop;
  logic                       run_tick;
  logic                       fifo_empty;
  logic [DIV_BITS-1:0]        div_last;
  logic [RESOLUTION_BITS-1:0] underrun_duty;

`ifdef PWM_SCHED_UNDERRUN_HOLD_EN
  assign underrun_duty = duty_q;
`else
  // Midscale gives 50% duty, which the PWM stage plays back as silence.
  assign underrun_duty = {1'b1, {(RESOLUTION_BITS-1){1'b0}}};
`endif

  // ready_q keeps s_ready low during reset and rises on the first edge after release.
  assign s_ready       = ready_q && (level_q != LvlW'(FIFO_DEPTH));
  assign fifo_level    = level_q;
  assign duty_out      = duty_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

  assign fifo_empty = (level_q == '0);
  // sample_div of 0 behaves as 1, so the last count is 0 in both cases.
  assign div_last   = (sample_div == '0) ? '0 : sample_div - DIV_BITS'(1);
  assign flush      = !enable && (state_q != StIdle);
  assign run_tick   = enable && (state_q == StRun) && (div_cnt_q >= div_last);
  assign push       = s_valid && s_ready && !flush;
  // Pop decision uses the registered level, so a same-cycle push into empty still underruns.
  assign pop        = run_tick && !fifo_empty;

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StPrime;
        StPrime: if (level_q >= LvlW'(PRIME_LEVEL)) state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      level_d = level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  always_comb begin
    div_cnt_d = '0;
    if (enable && (state_q == StRun) && !run_tick) div_cnt_d = div_cnt_q + DIV_BITS'(1);
  end

  always_comb begin
    duty_d     = duty_q;
    strobe_d   = pop;
    underrun_d = run_tick && fifo_empty;
    if (state_d != StRun) begin
      duty_d = '0;
    end else if (pop) begin
      duty_d = mem[rd_ptr_q];
    end else if (run_tick) begin
      duty_d = underrun_duty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      div_cnt_q  <= '0;
      duty_q     <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      div_cnt_q  <= div_cnt_d;
      duty_q     <= duty_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      ready_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Directed bench for pwm_sample_scheduler: scoreboard queue of pushed samples is popped and
// compared on each sample_strobe.
module tb_pwm_sample_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] sample_div;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [7:0]  duty_out;
  logic        sample_strobe;
  logic        underrun;
  logic [2:0]  fifo_level;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sb[$];
  logic [7:0]  exp_d;
  int          n;
  int          events;

`ifdef PWM_SCHED_UNDERRUN_HOLD_EN
  localparam logic [7:0] UnderrunDuty = 8'h40;
`else
  localparam logic [7:0] UnderrunDuty = 8'h80;
`endif

  pwm_sample_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .sample_div    (sample_div),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .duty_out      (duty_out),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    if (s_ready) sb.push_back(d);
    cycle();
    s_valid = 1'b0;
  endtask

  // Counts edges until a strobe or underrun, bounded so a dead DUT cannot hang the run.
  task automatic wait_event(output int cnt);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      cnt++;
      if (sample_strobe || underrun) break;
    end
  endtask

  task automatic pop_expect(output logic [7:0] e);
    if (sb.size() > 0) e = sb.pop_front();
    else e = 8'hxx;
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    sample_div = 16'd5;
    s_valid    = 1'b0;
    s_data     = 8'h00;

    // Reset state
    #2;
    check("rst_s_ready", s_ready, 0);
    check("rst_duty", duty_out, 0);
    check("rst_level", fifo_level, 0);
    check("rst_strobe", sample_strobe, 0);
    check("rst_underrun", underrun, 0);
    #10 rst_n = 1'b1;
    cycle();
    check("ready_after_release", s_ready, 1);

    // Prefill while disabled
    push(8'h10);
    push(8'h20);
    push(8'h30);
    check("level_3", fifo_level, 3);
    check("ready_3", s_ready, 1);
    push(8'h40);
    check("level_full", fifo_level, 4);
    check("ready_full", s_ready, 0);
    check("duty_idle", duty_out, 0);

    // Enable: IDLE -> PRIME -> RUN, then one sample every 5 cycles
    enable = 1'b1;
    cycle();
    cycle();
    for (int k = 0; k < 4; k++) begin
      wait_event(n);
      check("period_5", n, 5);
      check("strobe", sample_strobe, 1);
      pop_expect(exp_d);
      check("duty_seq", duty_out, exp_d);
    end
    check("level_drained", fifo_level, 0);

    // Empty FIFO on a tick
    wait_event(n);
    check("underrun_period", n, 5);
    check("underrun_pulse", underrun, 1);
    check("underrun_no_strobe", sample_strobe, 0);
    check("underrun_duty", duty_out, UnderrunDuty);

    // sample_div=0 with continuous input: first tick underruns, then a sample per cycle
    sample_div = 16'd0;
    s_valid    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 8'hA0 + 8'(i);
      sb.push_back(s_data);
      cycle();
      if (i == 0) begin
        check("div0_push_into_empty_underruns", underrun, 1);
      end else begin
        check("div0_strobe", sample_strobe, 1);
        check("div0_no_underrun", underrun, 0);
        pop_expect(exp_d);
        check("div0_duty", duty_out, exp_d);
      end
      check("div0_level", fifo_level, 1);
    end

    // Build level 3 with a long period, then drop enable
    sample_div = 16'd20;
    s_data     = 8'hB0;
    sb.push_back(s_data);
    cycle();
    s_data = 8'hB1;
    sb.push_back(s_data);
    cycle();
    s_valid = 1'b0;
    check("pre_flush_level", fifo_level, 3);
    check("pre_flush_no_strobe", sample_strobe, 0);
    enable = 1'b0;
    cycle();
    check("flush_level", fifo_level, 0);
    check("flush_duty", duty_out, 0);
    sb.delete();

    // Re-enable with one push: stays primed, no playback
    sample_div = 16'd2;
    enable     = 1'b1;
    push(8'h55);
    check("prime_level", fifo_level, 1);
    events = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (sample_strobe || underrun) events++;
    end
    check("prime_holds", events, 0);
    check("prime_duty", duty_out, 0);
    push(8'h66);
    wait_event(n);
    check("prime_to_first_strobe", n, 3);
    check("first_after_prime_strobe", sample_strobe, 1);
    pop_expect(exp_d);
    check("first_after_prime_duty", duty_out, exp_d);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("async_duty", duty_out, 0);
    check("async_level", fifo_level, 0);
    check("async_ready", s_ready, 0);
    check("async_strobe", sample_strobe, 0);
    check("async_underrun", underrun, 0);
    #2 rst_n = 1'b1;
    cycle();
    check("post_reset_level", fifo_level, 0);
    check("post_reset_ready", s_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
